// File: rtl/seg7_time_display.sv
// seg7_time_display: scans the Basys3 4-digit common-anode 7-segment display
// from shadowed BCD time digits, with HH.MM / MM.SS mode select and
// decimal-point indicators (blinking colon, PM flag).
module seg7_time_display #(
  parameter int REFRESH_DIV  = 100_000,
  parameter int BLANK_CYCLES = 2_000,
  parameter int DEBOUNCE     = 1_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       tick_1Hz,
  input  logic [3:0] hr_10s,
  input  logic [3:0] hr_1s,
  input  logic [3:0] min_10s,
  input  logic [3:0] min_1s,
  input  logic [3:0] sec_10s,
  input  logic [3:0] sec_1s,
  input  logic       am_pm,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       mode
);

  localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] BLANK_END = SW'(BLANK_CYCLES);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {IDX0 = 2'd0, IDX1 = 2'd1, IDX2 = 2'd2, IDX3 = 2'd3} idx_t;

  // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 shows a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] s;
    case (bcd)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  logic          tick_s1_r, tick_s2_r, tick_s3_r;
  logic          btn_s1_r, btn_s2_r;
  logic          tick_rise_s;
  logic [DW-1:0] db_cnt_r;
  logic          btn_stable_r;
  logic          press_s;
  logic [3:0]    sh_hr10_r, sh_hr1_r, sh_min10_r, sh_min1_r, sh_sec10_r, sh_sec1_r;
  logic          sh_am_pm_r;
  idx_t          idx_r, next_idx_s;
  logic [SW-1:0] slot_ctr_r, next_ctr_s;
  logic          frame_start_s;
  logic          pending_r;
  logic [3:0]    an_next_s;
  logic [6:0]    digit_seg_s;
  logic          digit_dp_s;

  // Synchronise the foreign tick and the raw button; third tick flop for edge detect.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      tick_s1_r <= 1'b0;
      tick_s2_r <= 1'b0;
      tick_s3_r <= 1'b0;
      btn_s1_r  <= 1'b0;
      btn_s2_r  <= 1'b0;
    end else begin
      tick_s1_r <= tick_1Hz;
      tick_s2_r <= tick_s1_r;
      tick_s3_r <= tick_s2_r;
      btn_s1_r  <= mode_btn;
      btn_s2_r  <= btn_s1_r;
    end
  end

  assign tick_rise_s = tick_s2_r & ~tick_s3_r;

  // Button must differ from the accepted level for DEBOUNCE consecutive cycles;
  // any return to the accepted level restarts the count.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      db_cnt_r     <= '0;
      btn_stable_r <= 1'b0;
    end else if (btn_s2_r == btn_stable_r) begin
      db_cnt_r <= '0;
    end else if (db_cnt_r == DB_LAST) begin
      db_cnt_r     <= '0;
      btn_stable_r <= btn_s2_r;
    end else begin
      db_cnt_r <= db_cnt_r + {{(DW-1){1'b0}}, 1'b1};
    end
  end

  // Accepted 0->1 transition of the debounced button, on the edge it is accepted.
  assign press_s = btn_s2_r && !btn_stable_r && (db_cnt_r == DB_LAST);

  // Capture a coherent time snapshot once per tick rising edge.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      sh_hr10_r  <= 4'd1;
      sh_hr1_r   <= 4'd2;
      sh_min10_r <= 4'd0;
      sh_min1_r  <= 4'd0;
      sh_sec10_r <= 4'd0;
      sh_sec1_r  <= 4'd0;
      sh_am_pm_r <= 1'b0;
    end else if (tick_rise_s) begin
      sh_hr10_r  <= hr_10s;
      sh_hr1_r   <= hr_1s;
      sh_min10_r <= min_10s;
      sh_min1_r  <= min_1s;
      sh_sec10_r <= sec_10s;
      sh_sec1_r  <= sec_1s;
      sh_am_pm_r <= am_pm;
    end
  end

  // Next slot position and the anode pattern that goes with it.
  always_comb begin
    next_ctr_s    = slot_ctr_r + {{(SW-1){1'b0}}, 1'b1};
    next_idx_s    = idx_r;
    frame_start_s = 1'b0;
    if (slot_ctr_r == SLOT_LAST) begin
      next_ctr_s    = '0;
      next_idx_s    = idx_t'(idx_r + 2'd1);
      frame_start_s = (idx_r == IDX3);
    end else begin
      next_ctr_s = slot_ctr_r + {{(SW-1){1'b0}}, 1'b1};
    end
    if (next_ctr_s < BLANK_END) begin
      an_next_s = 4'b1111;
    end else begin
      an_next_s = ~(4'b0001 << next_idx_s);
    end
  end

  // Segment and decimal point for the current slot from shadow values and mode.
  always_comb begin
    digit_seg_s = 7'b1111111;
    digit_dp_s  = 1'b1;
    case (idx_r)
      IDX0: begin
        if (mode) begin
          digit_seg_s = bcd_to_seg(sh_sec1_r);
          digit_dp_s  = 1'b1;
        end else begin
          digit_seg_s = bcd_to_seg(sh_min1_r);
          digit_dp_s  = ~sh_am_pm_r;
        end
      end
      IDX1: begin
        if (mode) begin
          digit_seg_s = bcd_to_seg(sh_sec10_r);
        end else begin
          digit_seg_s = bcd_to_seg(sh_min10_r);
        end
      end
      IDX2: begin
        if (mode) begin
          digit_seg_s = bcd_to_seg(sh_min1_r);
          digit_dp_s  = 1'b0;
        end else begin
          digit_seg_s = bcd_to_seg(sh_hr1_r);
          digit_dp_s  = ~tick_s2_r;
        end
      end
      IDX3: begin
        if (mode) begin
          digit_seg_s = bcd_to_seg(sh_min10_r);
        end else if (sh_hr10_r == 4'd0) begin
          digit_seg_s = 7'b1111111;
        end else begin
          digit_seg_s = bcd_to_seg(sh_hr10_r);
        end
      end
      default: begin
        digit_seg_s = 7'b1111111;
        digit_dp_s  = 1'b1;
      end
    endcase
  end

  // Scan FSM: slot timing, frame-aligned mode toggle and registered pin drive.
  // seg/dp load on the first cycle of each slot, which is always blanked.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      idx_r      <= IDX0;
      slot_ctr_r <= '0;
      mode       <= 1'b0;
      pending_r  <= 1'b0;
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
    end else begin
      idx_r      <= next_idx_s;
      slot_ctr_r <= next_ctr_s;
      an         <= an_next_s;
      if (frame_start_s) begin
        mode      <= mode ^ pending_r;
        pending_r <= press_s;
      end else begin
        pending_r <= pending_r | press_s;
      end
      if (slot_ctr_r == '0) begin
        seg <= digit_seg_s;
        dp  <= digit_dp_s;
      end
    end
  end

endmodule

// File: tb/tb_seg7_time_display.sv
// Scoreboard bench for seg7_time_display: stimulus pushes the expected
// contents of one full frame; a monitor pops one entry at the start of each
// un-blanked slot and compares it against the pins.
module tb_seg7_time_display;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S7 = 7'b1111000, S9 = 7'b0010000,
                         SBLK = 7'b1111111, SDASH = 7'b0111111;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       mode;
  } exp_t;

  logic       clk_100MHz = 1'b0;
  logic       reset = 1'b1;
  logic       mode_btn = 1'b0;
  logic       tick_1Hz = 1'b0;
  logic [3:0] hr_10s = 4'd1, hr_1s = 4'd2, min_10s = 4'd0, min_1s = 4'd0;
  logic [3:0] sec_10s = 4'd0, sec_1s = 4'd0;
  logic       am_pm = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       mode;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  seg7_time_display #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .DEBOUNCE(4)) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .mode_btn(mode_btn), .tick_1Hz(tick_1Hz),
    .hr_10s(hr_10s), .hr_1s(hr_1s), .min_10s(min_10s), .min_1s(min_1s),
    .sec_10s(sec_10s), .sec_1s(sec_1s), .am_pm(am_pm),
    .seg(seg), .dp(dp), .an(an), .mode(mode)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one scoreboard entry per slot, popped as the anode comes on.
  logic [3:0] mon_prev_an = 4'b1111;
  always @(negedge clk_100MHz) begin
    exp_t e;
    if (!reset && an != 4'b1111 && mon_prev_an == 4'b1111 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({an, seg, dp, mode} !== e) begin
        n_fail++;
        $display("FAIL slot: got an=%b seg=%b dp=%b mode=%b, expected an=%b seg=%b dp=%b mode=%b",
                 an, seg, dp, mode, e.an, e.seg, e.dp, e.mode);
      end
    end
    mon_prev_an <= an;
  end

  // Wait for the next frame start, push the four expected slots, wait for the monitor to drain them.
  task automatic expect_frame(input logic m, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dps);
    logic [3:0] prev = 4'b1111;
    bit found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_100MHz);
      if (an != 4'b1111) prev = an;
      else if (prev == 4'b0111) begin found = 1; break; end
    end
    if (!found) begin
      n_cmp++; n_fail++;
      $display("FAIL frame_start_timeout: no frame start within 100 cycles");
      return;
    end
    exp_q.push_back('{4'b1110, s0, dps[0], m});
    exp_q.push_back('{4'b1101, s1, dps[1], m});
    exp_q.push_back('{4'b1011, s2, dps[2], m});
    exp_q.push_back('{4'b0111, s3, dps[3], m});
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk_100MHz);
    if (exp_q.size() > 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: %0d entries left", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Called at the negedge where reset was just released: check the anode sequence.
  task automatic check_scan_start();
    logic [3:0] req;
    for (int i = 0; i < 16; i++) begin
      #1;
      req = (i < 2) ? 4'b1111 : (i < 8) ? 4'b1110 : (i < 10) ? 4'b1111 : 4'b1101;
      check($sformatf("scan_an[%0d]", i), {28'd0, an}, {28'd0, req});
      @(negedge clk_100MHz);
    end
  endtask

  // Press the button long enough and require mode to flip exactly at IDX3->IDX0.
  task automatic press_and_check_toggle(input logic new_mode);
    logic [3:0] prev_an;
    bit found = 0;
    mode_btn = 1'b1;
    repeat (10) @(negedge clk_100MHz);
    mode_btn = 1'b0;
    prev_an = an;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk_100MHz);
      if (mode == new_mode) begin
        check("toggle_point", {24'd0, prev_an, an}, {24'd0, 4'b0111, 4'b1111});
        found = 1;
        break;
      end
      prev_an = an;
    end
    if (!found) begin
      n_cmp++; n_fail++;
      $display("FAIL toggle_timeout: mode=%b, expected %b", mode, new_mode);
    end
  endtask

  task automatic set_time(input logic [3:0] h1, input logic [3:0] h0, input logic [3:0] m1,
                          input logic [3:0] m0, input logic [3:0] s1, input logic [3:0] s0,
                          input logic pm);
    hr_10s = h1; hr_1s = h0; min_10s = m1; min_1s = m0; sec_10s = s1; sec_1s = s0; am_pm = pm;
  endtask

  task automatic pulse_tick();
    tick_1Hz = 1'b1;
    repeat (4) @(negedge clk_100MHz);
    tick_1Hz = 1'b0;
    repeat (4) @(negedge clk_100MHz);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int toggles;
    logic last_mode;

    // 1. Reset values, scan order, 12:00 AM.
    repeat (3) @(negedge clk_100MHz);
    #1;
    check("reset_an", {28'd0, an}, {28'd0, 4'b1111});
    check("reset_seg", {25'd0, seg}, {25'd0, SBLK});
    check("reset_dp", {31'd0, dp}, 32'd1);
    check("reset_mode", {31'd0, mode}, 32'd0);
    @(negedge clk_100MHz);
    reset = 1'b0;
    check_scan_start();
    expect_frame(1'b0, S0, S0, S2, S1, 4'b1111);

    // 2. Capture 09:45:37 PM on a tick edge; leading-zero blank, PM dot.
    set_time(4'd0, 4'd9, 4'd4, 4'd5, 4'd3, 4'd7, 1'b1);
    pulse_tick();
    expect_frame(1'b0, S5, S4, S9, SBLK, 4'b1110);
    // Inputs change without a tick edge: display holds.
    set_time(4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 1'b0);
    repeat (10) @(negedge clk_100MHz);
    expect_frame(1'b0, S5, S4, S9, SBLK, 4'b1110);
    // Colon lit while tick is high.
    set_time(4'd0, 4'd9, 4'd4, 4'd5, 4'd3, 4'd7, 1'b1);
    tick_1Hz = 1'b1;
    repeat (6) @(negedge clk_100MHz);
    expect_frame(1'b0, S5, S4, S9, SBLK, 4'b1010);
    tick_1Hz = 1'b0;
    repeat (4) @(negedge clk_100MHz);

    // 3. Short press ignored; long press toggles at frame start.
    mode_btn = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    mode_btn = 1'b0;
    repeat (80) @(negedge clk_100MHz);
    check("short_press_mode", {31'd0, mode}, 32'd0);
    press_and_check_toggle(1'b1);
    expect_frame(1'b1, S7, S3, S5, S4, 4'b1011);

    // 4. Chatter then hold: exactly one toggle.
    toggles = 0;
    last_mode = mode;
    for (int i = 0; i < 130; i++) begin
      if (i < 20) mode_btn = (i % 2 == 0);
      else if (i < 30) mode_btn = 1'b1;
      else mode_btn = 1'b0;
      @(negedge clk_100MHz);
      if (mode != last_mode) toggles++;
      last_mode = mode;
    end
    check("bounce_toggles", toggles, 32'd1);
    check("bounce_mode", {31'd0, mode}, 32'd0);
    expect_frame(1'b0, S5, S4, S9, SBLK, 4'b1110);

    // 5. Invalid BCD shows a dash.
    min_1s = 4'hB;
    pulse_tick();
    expect_frame(1'b0, SDASH, S4, S9, SBLK, 4'b1110);

    // 6. Asynchronous reset in an un-blanked IDX2 slot, with mode = 1.
    press_and_check_toggle(1'b1);
    for (int i = 0; i < 100 && an != 4'b1011; i++) @(negedge clk_100MHz);
    check("idx2_reached", {28'd0, an}, {28'd0, 4'b1011});
    #1 reset = 1'b1;
    #1;
    check("midreset_an", {28'd0, an}, {28'd0, 4'b1111});
    check("midreset_seg", {25'd0, seg}, {25'd0, SBLK});
    check("midreset_dp", {31'd0, dp}, 32'd1);
    check("midreset_mode", {31'd0, mode}, 32'd0);
    repeat (2) @(negedge clk_100MHz);
    reset = 1'b0;
    check_scan_start();
    expect_frame(1'b0, S0, S0, S2, S1, 4'b1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
